inst_issue_buffer: RTL

- Instruction buffer between fetch and the dual-issue decode stage.
- Accepts up to two fetched instructions per cycle, each with PC and branch-prediction correction pack.
- Presents the two oldest entries to decode and retires 1 or 2 entries according to decode's issue decision.
- Tracks the delay-slot flag for the next head instruction; flushes on redirect.

---
 rtl/inst_issue_buffer_pkg.sv | 28 ++
 rtl/inst_issue_buffer_storage.sv | 32 +++
 rtl/inst_issue_buffer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/inst_issue_buffer_pkg.sv
// Shared widths, issue-mode encodings and entry record for the instruction issue buffer.
package inst_issue_buffer_pkg;

  localparam int SIZE_OF_CORR_PACK = 88;
  localparam int INST_W            = 32;
  localparam int ADDR_W            = 32;

  localparam logic DUAL_ISSUE   = 1'b1;
  localparam logic SINGLE_ISSUE = 1'b0;

  typedef struct packed {
    logic [INST_W-1:0]            inst;
    logic [ADDR_W-1:0]            addr;
    logic [SIZE_OF_CORR_PACK-1:0] corr;
  } ibuf_entry_t;

  // Entries retired this cycle: decode may only take what is actually present.
  function automatic logic [1:0] pop_count(input logic issued, input logic mode,
                                           input logic has_one, input logic has_two);
    logic [1:0] n;
    n = 2'd0;
    if (issued && has_one) begin
      n = (mode == DUAL_ISSUE && has_two) ? 2'd2 : 2'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/inst_issue_buffer_storage.sv
// Entry array for the issue buffer: two write ports, two asynchronous read ports.
// Contents are not reset; validity is tracked by the occupancy count in the top.
module ibuf_storage #(
  parameter int DEPTH   = 16,
  parameter int PTR_W   = 4,
  parameter int ENTRY_W = 152
) (
  input  logic               clk,
  input  logic               we0,
  input  logic [PTR_W-1:0]   waddr0,
  input  logic [ENTRY_W-1:0] wdata0,
  input  logic               we1,
  input  logic [PTR_W-1:0]   waddr1,
  input  logic [ENTRY_W-1:0] wdata1,
  input  logic [PTR_W-1:0]   raddr0,
  output logic [ENTRY_W-1:0] rdata0,
  input  logic [PTR_W-1:0]   raddr1,
  output logic [ENTRY_W-1:0] rdata1
);

  logic [ENTRY_W-1:0] mem_reg [DEPTH];

  // The two write addresses are always consecutive slots, so they never collide.
  always_ff @(posedge clk) begin
    if (we0) mem_reg[waddr0] <= wdata0;
    if (we1) mem_reg[waddr1] <= wdata1;
  end

  assign rdata0 = mem_reg[raddr0];
  assign rdata1 = mem_reg[raddr1];

endmodule

// File: rtl/inst_issue_buffer.sv
// Instruction buffer between fetch and dual-issue decode, with delay-slot tracking.
// Optional performance counters are built when IBUF_PERF_STAT_EN is defined.
module inst_issue_buffer
  import inst_issue_buffer_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4,
  parameter int CORR_W = SIZE_OF_CORR_PACK
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush_i,
  input  logic              fetch_valid1_i,
  input  logic              fetch_valid2_i,
  input  logic [31:0]       fetch_inst1_i,
  input  logic [31:0]       fetch_inst2_i,
  input  logic [31:0]       fetch_addr1_i,
  input  logic [31:0]       fetch_addr2_i,
  input  logic [CORR_W-1:0] fetch_corr1_i,
  input  logic [CORR_W-1:0] fetch_corr2_i,
  output logic              full_o,
  output logic [31:0]       inst1_o,
  output logic [31:0]       inst2_o,
  output logic [31:0]       inst1_addr_o,
  output logic [31:0]       inst2_addr_o,
  output logic [CORR_W-1:0] inst1_corr_o,
  output logic [CORR_W-1:0] inst2_corr_o,
  output logic              issue_en_o,
  output logic              inst2_valid_o,
  input  logic              issue_mode_i,
  input  logic              issued_i,
  input  logic              ninst_in_delayslot_i,
`ifdef IBUF_PERF_STAT_EN
  output logic [31:0]       perf_dual_cnt_o,
  output logic [31:0]       perf_empty_cnt_o,
`endif
  output logic              is_in_delayslot_o
);

  localparam int ENTRY_W = INST_W + ADDR_W + CORR_W;
  localparam logic [PTR_W:0] FULL_LIMIT = (PTR_W+1)'(DEPTH - 2);
  localparam logic [PTR_W:0] TWO        = (PTR_W+1)'(2);

  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PTR_W:0]     count_reg, count_next;
  logic               ds_flag_reg, ds_flag_next;

  logic [1:0]         push_cnt;
  logic [1:0]         pop_cnt;
  logic               has_one;
  logic               has_two;
  logic               we0, we1;
  logic [ENTRY_W-1:0] slot1_data, slot2_data, wdata0;
  logic [ENTRY_W-1:0] rdata0, rdata1;

  assign has_one    = (count_reg != '0);
  assign has_two    = (count_reg >= TWO);
  assign full_o     = (count_reg > FULL_LIMIT);
  assign slot1_data = {fetch_inst1_i, fetch_addr1_i, fetch_corr1_i};
  assign slot2_data = {fetch_inst2_i, fetch_addr2_i, fetch_corr2_i};

  always_comb begin
    push_cnt     = 2'd0;
    pop_cnt      = 2'd0;
    rd_ptr_next  = rd_ptr_reg;
    wr_ptr_next  = wr_ptr_reg;
    count_next   = count_reg;
    ds_flag_next = ds_flag_reg;
    if (flush_i) begin
      rd_ptr_next  = '0;
      wr_ptr_next  = '0;
      count_next   = '0;
      ds_flag_next = 1'b0;
    end else begin
      if (!full_o) begin
        push_cnt = {1'b0, fetch_valid1_i} + {1'b0, fetch_valid2_i};
      end
      pop_cnt     = pop_count(issued_i, issue_mode_i, has_one, has_two);
      rd_ptr_next = rd_ptr_reg + PTR_W'(pop_cnt);
      wr_ptr_next = wr_ptr_reg + PTR_W'(push_cnt);
      count_next  = count_reg + (PTR_W+1)'(push_cnt) - (PTR_W+1)'(pop_cnt);
      if (issued_i) begin
        ds_flag_next = ninst_in_delayslot_i;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
      count_reg   <= '0;
      ds_flag_reg <= 1'b0;
    end else begin
      rd_ptr_reg  <= rd_ptr_next;
      wr_ptr_reg  <= wr_ptr_next;
      count_reg   <= count_next;
      ds_flag_reg <= ds_flag_next;
    end
  end

  // Pushes are compacted: a lone slot-2 instruction still lands at wr_ptr.
  assign we0    = (push_cnt != 2'd0);
  assign we1    = (push_cnt == 2'd2);
  assign wdata0 = fetch_valid1_i ? slot1_data : slot2_data;

  ibuf_storage #(
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W),
    .ENTRY_W(ENTRY_W)
  ) u_storage (
    .clk   (clk),
    .we0   (we0),
    .waddr0(wr_ptr_reg),
    .wdata0(wdata0),
    .we1   (we1),
    .waddr1(wr_ptr_reg + PTR_W'(1)),
    .wdata1(slot2_data),
    .raddr0(rd_ptr_reg),
    .rdata0(rdata0),
    .raddr1(rd_ptr_reg + PTR_W'(1)),
    .rdata1(rdata1)
  );

  assign issue_en_o        = has_one;
  assign inst2_valid_o     = has_two;
  assign is_in_delayslot_o = ds_flag_reg;

  assign inst1_o      = has_one ? rdata0[ENTRY_W-1 -: INST_W]      : '0;
  assign inst1_addr_o = has_one ? rdata0[CORR_W +: ADDR_W]         : '0;
  assign inst1_corr_o = has_one ? rdata0[CORR_W-1:0]               : '0;
  assign inst2_o      = has_two ? rdata1[ENTRY_W-1 -: INST_W]      : '0;
  assign inst2_addr_o = has_two ? rdata1[CORR_W +: ADDR_W]         : '0;
  assign inst2_corr_o = has_two ? rdata1[CORR_W-1:0]               : '0;

`ifdef IBUF_PERF_STAT_EN
  logic [31:0] perf_dual_reg;
  logic [31:0] perf_empty_reg;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_dual_reg  <= '0;
      perf_empty_reg <= '0;
    end else begin
      if (pop_cnt == 2'd2)       perf_dual_reg  <= perf_dual_reg + 32'd1;
      if (!has_one && !flush_i)  perf_empty_reg <= perf_empty_reg + 32'd1;
    end
  end

  assign perf_dual_cnt_o  = perf_dual_reg;
  assign perf_empty_cnt_o = perf_empty_reg;
`endif

endmodule
